// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline: load-use stall,
// taken-branch flush, EX operand forwarding selects and a stall-cycle counter.
module hazard_unit #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           id_addr_rs1,
   input  logic [4:0]           id_addr_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic                 ex_mem_re,
   input  logic                 ex_reg_file_write,
   input  logic [4:0]           ex_addr_rd,
   input  logic                 ex_branch_taken,
   output logic                 stall_pc,
   output logic                 stall_if_id,
   output logic                 bubble_id_ex,
   output logic                 flush_if_id,
   output logic [1:0]           fwd_a,
   output logic [1:0]           fwd_b,
   output logic [CNT_WIDTH-1:0] stall_count
);

   logic                 luse_s;
   logic [4:0]           ex_rs1_r;
   logic [4:0]           ex_rs2_r;
   logic                 ex_use1_r;
   logic                 ex_use2_r;
   logic [4:0]           mem_rd_r;
   logic                 mem_we_r;
   logic                 mem_re_r;
   logic [4:0]           wb_rd_r;
   logic                 wb_we_r;
   logic [CNT_WIDTH-1:0] stall_count_r;

   // Forward select for one operand; a load still in MEM has no data yet, and x0 never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic       use_rs,
      input logic [4:0] rs,
      input logic       m_we,
      input logic       m_re,
      input logic [4:0] m_rd,
      input logic       w_we,
      input logic [4:0] w_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_rs && m_we && !m_re && (m_rd != 5'd0) && (m_rd == rs)) begin
         sel = 2'b01;
      end else if (use_rs && w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Load-use detect against the load currently in EX.
   always_comb begin
      luse_s = 1'b0;
      if (ex_mem_re && ex_reg_file_write && (ex_addr_rd != 5'd0)) begin
         if ((id_uses_rs1 && (id_addr_rs1 == ex_addr_rd)) ||
             (id_uses_rs2 && (id_addr_rs2 == ex_addr_rd))) begin
            luse_s = 1'b1;
         end else begin
            luse_s = 1'b0;
         end
      end else begin
         luse_s = 1'b0;
      end
   end

   // Pipeline controls; a taken branch overrides a stall, reset forces everything idle.
   always_comb begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      flush_if_id  = 1'b0;
      if (!reset) begin
         stall_pc     = 1'b0;
         stall_if_id  = 1'b0;
         bubble_id_ex = 1'b0;
         flush_if_id  = 1'b0;
      end else if (ex_branch_taken) begin
         flush_if_id  = 1'b1;
         bubble_id_ex = 1'b1;
      end else if (luse_s) begin
         stall_pc     = 1'b1;
         stall_if_id  = 1'b1;
         bubble_id_ex = 1'b1;
      end else begin
         stall_pc     = 1'b0;
         stall_if_id  = 1'b0;
         bubble_id_ex = 1'b0;
         flush_if_id  = 1'b0;
      end
   end

   // Shadow copies of the register fields of the instructions in EX, MEM and WB.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_rs1_r  <= 5'd0;
         ex_rs2_r  <= 5'd0;
         ex_use1_r <= 1'b0;
         ex_use2_r <= 1'b0;
         mem_rd_r  <= 5'd0;
         mem_we_r  <= 1'b0;
         mem_re_r  <= 1'b0;
         wb_rd_r   <= 5'd0;
         wb_we_r   <= 1'b0;
      end else begin
         if (bubble_id_ex) begin
            ex_rs1_r  <= 5'd0;
            ex_rs2_r  <= 5'd0;
            ex_use1_r <= 1'b0;
            ex_use2_r <= 1'b0;
         end else begin
            ex_rs1_r  <= id_addr_rs1;
            ex_rs2_r  <= id_addr_rs2;
            ex_use1_r <= id_uses_rs1;
            ex_use2_r <= id_uses_rs2;
         end
         mem_rd_r <= ex_addr_rd;
         mem_we_r <= ex_reg_file_write;
         mem_re_r <= ex_mem_re;
         wb_rd_r  <= mem_rd_r;
         wb_we_r  <= mem_we_r;
      end
   end

   // Saturating count of cycles actually spent in a load-use stall.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_count_r <= {CNT_WIDTH{1'b0}};
      end else if (luse_s && !ex_branch_taken && (stall_count_r != {CNT_WIDTH{1'b1}})) begin
         stall_count_r <= stall_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign fwd_a       = fwd_sel(ex_use1_r, ex_rs1_r, mem_we_r, mem_re_r, mem_rd_r, wb_we_r, wb_rd_r);
   assign fwd_b       = fwd_sel(ex_use2_r, ex_rs2_r, mem_we_r, mem_re_r, mem_rd_r, wb_we_r, wb_rd_r);
   assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: reset, load-use, forwarding,
// priority, branch-versus-stall, reset mid-stall and counter saturation.
module tb_hazard_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  id_addr_rs1;
   logic [4:0]  id_addr_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic        ex_mem_re;
   logic        ex_reg_file_write;
   logic [4:0]  ex_addr_rd;
   logic        ex_branch_taken;
   logic        stall_pc;
   logic        stall_if_id;
   logic        bubble_id_ex;
   logic        flush_if_id;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [15:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_unit #(.CNT_WIDTH(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .id_addr_rs1       (id_addr_rs1),
      .id_addr_rs2       (id_addr_rs2),
      .id_uses_rs1       (id_uses_rs1),
      .id_uses_rs2       (id_uses_rs2),
      .ex_mem_re         (ex_mem_re),
      .ex_reg_file_write (ex_reg_file_write),
      .ex_addr_rd        (ex_addr_rd),
      .ex_branch_taken   (ex_branch_taken),
      .stall_pc          (stall_pc),
      .stall_if_id       (stall_if_id),
      .bubble_id_ex      (bubble_id_ex),
      .flush_if_id       (flush_if_id),
      .fwd_a             (fwd_a),
      .fwd_b             (fwd_b),
      .stall_count       (stall_count)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic spc, input logic sif,
                          input logic bub, input logic fl);
      check_eq({tag, ".stall_pc"},     {31'd0, stall_pc},     {31'd0, spc});
      check_eq({tag, ".stall_if_id"},  {31'd0, stall_if_id},  {31'd0, sif});
      check_eq({tag, ".bubble_id_ex"}, {31'd0, bubble_id_ex}, {31'd0, bub});
      check_eq({tag, ".flush_if_id"},  {31'd0, flush_if_id},  {31'd0, fl});
   endtask

   task automatic chk_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
      check_eq({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, ea});
      check_eq({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, eb});
   endtask

   task automatic set_id(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
      id_addr_rs1 = r1;
      id_addr_rs2 = r2;
      id_uses_rs1 = u1;
      id_uses_rs2 = u2;
   endtask

   task automatic set_ex(input logic re, input logic we, input logic [4:0] rd, input logic br);
      ex_mem_re         = re;
      ex_reg_file_write = we;
      ex_addr_rd        = rd;
      ex_branch_taken   = br;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      set_ex(1'b0, 1'b0, 5'd0, 1'b0);
      repeat (n) step();
   endtask

   initial begin
      // Reset held with a load-use pattern present.
      reset = 1'b0;
      set_id(5'd5, 5'd0, 1'b1, 1'b0);
      set_ex(1'b1, 1'b1, 5'd5, 1'b0);
      #1;
      chk_ctl("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk_ctl("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_fwd("rst1", 2'b00, 2'b00);
      check_eq("rst1.count", {16'd0, stall_count}, 32'd0);
      step();
      chk_ctl("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst2.count", {16'd0, stall_count}, 32'd0);
      reset = 1'b1;
      idle(2);

      // Load-use: lw x5 in EX, ID reads x5.
      set_ex(1'b1, 1'b1, 5'd5, 1'b0);
      set_id(5'd5, 5'd0, 1'b1, 1'b0);
      #1;
      chk_ctl("luse", 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      set_ex(1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      chk_ctl("luse_after", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("luse.count", {16'd0, stall_count}, 32'd1);
      chk_fwd("luse_bubble", 2'b00, 2'b00);
      step();
      set_ex(1'b0, 1'b1, 5'd6, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      chk_fwd("luse_wb", 2'b10, 2'b00);
      idle(3);

      // lw x0 never stalls.
      set_ex(1'b1, 1'b1, 5'd0, 1'b0);
      set_id(5'd0, 5'd0, 1'b1, 1'b1);
      #1;
      chk_ctl("lw_x0", 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);

      // add x3 ; sub x?, x3, x3 back to back.
      set_ex(1'b0, 1'b1, 5'd3, 1'b0);
      set_id(5'd3, 5'd3, 1'b1, 1'b1);
      #1;
      chk_ctl("alu_nostall", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(1'b0, 1'b1, 5'd4, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      chk_fwd("alu_mem", 2'b01, 2'b01);
      idle(3);

      // add x3 ; unrelated ; sub using x3.
      set_ex(1'b0, 1'b1, 5'd3, 1'b0);
      set_id(5'd1, 5'd2, 1'b0, 1'b0);
      step();
      set_ex(1'b0, 1'b0, 5'd0, 1'b0);
      set_id(5'd3, 5'd3, 1'b1, 1'b1);
      #1;
      chk_fwd("alu_gap_mid", 2'b00, 2'b00);
      step();
      set_ex(1'b0, 1'b1, 5'd8, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      chk_fwd("alu_wb", 2'b10, 2'b10);
      idle(3);

      // MEM and WB both write x7; MEM wins.
      set_ex(1'b0, 1'b1, 5'd7, 1'b0);
      step();
      set_ex(1'b0, 1'b1, 5'd7, 1'b0);
      set_id(5'd7, 5'd7, 1'b1, 1'b1);
      step();
      set_ex(1'b0, 1'b0, 5'd0, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      chk_fwd("prio_x7", 2'b01, 2'b01);
      idle(3);

      // Writes to x0 in MEM and WB are never forwarded.
      set_ex(1'b0, 1'b1, 5'd0, 1'b0);
      step();
      set_ex(1'b0, 1'b1, 5'd0, 1'b0);
      set_id(5'd0, 5'd0, 1'b1, 1'b1);
      step();
      set_ex(1'b0, 1'b0, 5'd0, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      chk_fwd("x0", 2'b00, 2'b00);
      idle(3);

      // Branch taken while load-use holds, then the stall alone.
      set_ex(1'b1, 1'b1, 5'd5, 1'b1);
      set_id(5'd0, 5'd5, 1'b0, 1'b1);
      #1;
      chk_ctl("br_luse", 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      check_eq("br_luse.count", {16'd0, stall_count}, 32'd1);
      ex_branch_taken = 1'b0;
      #1;
      chk_ctl("b2b_stall", 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      check_eq("b2b.count", {16'd0, stall_count}, 32'd2);

      // Reset asserted mid-stall.
      reset = 1'b0;
      #1;
      chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check_eq("rst_mid.count", {16'd0, stall_count}, 32'd0);
      chk_fwd("rst_mid", 2'b00, 2'b00);
      reset = 1'b1;

      // Saturation: 65535 stall cycles reach all-ones, one more holds it.
      set_ex(1'b1, 1'b1, 5'd5, 1'b0);
      set_id(5'd5, 5'd0, 1'b1, 1'b0);
      repeat (65535) step();
      check_eq("sat.full", {16'd0, stall_count}, 32'h0000_FFFF);
      chk_ctl("sat", 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      check_eq("sat.hold", {16'd0, stall_count}, 32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard and forwarding controller for the 5-stage pipeline; it consumes the decode-side fields and the ID/EX register outputs. It keeps a shadow copy of the source/destination fields of the instructions in EX, MEM and WB. From these it drives:
- load-use stall, bubble and taken-branch flush controls for PC, IF/ID and ID/EX;
- the EX-stage operand forwarding selects;
- a saturating stall-cycle counter for performance monitoring.

## Interface
- CNT_WIDTH, 16, width of the stall-cycle counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge; low = reset)
- id_addr_rs1  in  5  rs1 of instruction in ID
- id_addr_rs2  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_re  in  1  ID/EX mem_re output (instruction in EX is a load)
- ex_reg_file_write  in  1  ID/EX reg_file_write output
- ex_addr_rd  in  5  ID/EX addr_rd output
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- bubble_id_ex  out  1  load all-zero controls into ID/EX at next edge
- flush_if_id  out  1  load NOP into IF/ID at next edge
- fwd_a  out  2  EX operand A source: 00 reg file, 01 EX/MEM result, 10 MEM/WB result
- fwd_b  out  2  EX operand B source, same encoding
- stall_count  out  CNT_WIDTH  saturating count of load-use stall cycles

## Operation
- Shadow state, all cleared by reset:
  - EX slot: ex_rs1_q, ex_rs2_q, ex_use1_q, ex_use2_q
  - MEM slot: mem_rd_q, mem_we_q, mem_re_q
  - WB slot: wb_rd_q, wb_we_q
- Load-use detect (combinational), luse = 1 when all of:
  - ex_mem_re = 1, ex_reg_file_write = 1 and ex_addr_rd != 0;
  - (id_uses_rs1 = 1 and id_addr_rs1 == ex_addr_rd) or (id_uses_rs2 = 1 and id_addr_rs2 == ex_addr_rd).
- Flush has priority over stall:
  - ex_branch_taken = 1: flush_if_id = 1, bubble_id_ex = 1, stall_pc = 0, stall_if_id = 0.
  - else luse = 1: stall_pc = 1, stall_if_id = 1, bubble_id_ex = 1, flush_if_id = 0.
  - else all four = 0.
- Shadow update each edge:
  - EX slot loads the id_* fields, or zeros (use bits = 0) when bubble_id_ex = 1.
  - MEM slot loads ex_addr_rd, ex_reg_file_write and ex_mem_re.
  - WB slot loads mem_rd_q and mem_we_q.
- Forwarding for fwd_a (fwd_b identical, using rs2):
  - 01 if ex_use1_q, mem_we_q, !mem_re_q, mem_rd_q != 0 and mem_rd_q == ex_rs1_q;
  - else 10 if ex_use1_q, wb_we_q, wb_rd_q != 0 and wb_rd_q == ex_rs1_q;
  - else 00.
  - MEM beats WB when both match. x0 is never forwarded.
- stall_count increments by 1 on each edge where luse = 1 and ex_branch_taken = 0. It saturates at all-ones and never wraps.

## Timing
- While reset is low:
  - stall_pc, stall_if_id, bubble_id_ex and flush_if_id are forced to 0;
  - at the edge, all shadow state and stall_count are cleared, so fwd_a = fwd_b = 00 from the following cycle.
- Stall/flush/bubble outputs are combinational from the current inputs: zero-cycle latency, effective at the next edge.
- fwd_a and fwd_b are combinational from registered state only: valid from the start of the cycle, no input-to-output path.
- A load-use stall lasts exactly 1 cycle:
  - after the bubble, the load sits in MEM and luse deasserts;
  - the dependent instruction then enters EX while the load is in WB and gets fwd = 10.
- Back-to-back flush then stall is allowed; each cycle is decided independently.
- Reset asserted mid-stall: that cycle's outputs are 0 and the stall is dropped. After release, the unit behaves as from power-up.

## Test plan
- Reset: hold reset low 2 cycles with luse conditions present. Required: all control outputs 0 throughout, and fwd_a = fwd_b = 00 and stall_count = 0 after the reset edge.
- Load-use: EX = lw x5 (ex_mem_re = 1, ex_reg_file_write = 1, ex_addr_rd = 5); ID uses rs1 = 5. Required:
  - stall_pc, stall_if_id and bubble_id_ex = 1 for exactly 1 cycle;
  - stall_count goes 0 -> 1;
  - two cycles later fwd_a = 10.
- ALU forwarding: add x3 followed immediately by sub using rs1 = 3 and rs2 = 3. Required: fwd_a = fwd_b = 01 in the consumer's EX cycle. With one unrelated instruction between them, both selects are 10.
- Priority: MEM and WB both write x7, EX reads x7 → fwd = 01. Destination x0 with matching reads → fwd = 00.
- Branch vs load-use in the same cycle: ex_branch_taken = 1 while luse conditions hold. Required: flush_if_id = 1, bubble_id_ex = 1, stall_pc = 0, and stall_count unchanged.
- Saturation: preload stall_count to 0xFFFF, then apply a load-use stall. Required: stall_count stays 0xFFFF.
